// File: rtl/ppu_pkg.sv
// Shared types and constants for the post-processing unit sequencer.
package ppu_pkg;

  localparam int MAXPOOL_WIN = 4;
  localparam int CFG_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ppu_state_e;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] num_out;
    logic                 maxpool;
    logic                 relu_en;
    logic                 relu_sel;
    logic [5:0]           scale;
  } ppu_cfg_t;

  // A beat closes its window when pooling is off, or on the last slot of a 2x2 window.
  function automatic logic is_win_last(input logic maxpool, input logic [1:0] win_cnt);
    return !maxpool || (win_cnt == 2'(MAXPOOL_WIN - 1));
  endfunction

endpackage

// File: rtl/ppu_ofifo.sv
// Small synchronous byte FIFO holding PPU results until the GLB writer takes them.
module ppu_ofifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  head_data,
  output logic [AW:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;

  assign full = (count_q == (AW + 1)'(DEPTH));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full)) else $error("ppu_ofifo: push into full FIFO");
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/ppu_ctrl.sv
// Sequencer feeding the PPU per element, tracking its latency and buffering results.
module ppu_ctrl
  import ppu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PPU_LAT     = 2,
  parameter int OFIFO_DEPTH = 4,
  parameter int CNT_W       = CFG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_out,
  input  logic              cfg_maxpool,
  input  logic              cfg_relu_en,
  input  logic              cfg_relu_sel,
  input  logic [5:0]        cfg_scale,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] ppu_data_in,
  output logic [5:0]        ppu_scale,
  output logic              ppu_maxpool_en,
  output logic              ppu_maxpool_init,
  output logic              ppu_relu_en,
  output logic              ppu_relu_sel,
  input  logic [7:0]        ppu_data_out,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int FCW = $clog2(OFIFO_DEPTH) + 1;

  ppu_state_e        state_q, state_d;
  ppu_cfg_t          cfg_q, cfg_d;
  logic [1:0]        win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  last_cnt_q, last_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              issue_last_q, issue_last_d;
  logic [PPU_LAT-1:0] lat_q, lat_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              mp_en_q, mp_en_d;
  logic              mp_init_q, mp_init_d;
  logic              zero_done_q, zero_done_d;

  logic              next_is_last, room, accept, push, pop, drain_done;
  logic [FCW-1:0]    fifo_count;
  logic [7:0]        fifo_head;
  int                inflight;

  // Results in flight: the beat on the PPU pins plus every bit in the latency pipe.
  always_comb begin
    inflight     = $countones({lat_q, issue_last_q});
    room         = (int'(fifo_count) + inflight) < OFIFO_DEPTH;
    next_is_last = is_win_last(cfg_q.maxpool, win_cnt_q);
    in_ready     = (state_q == RUN) && (!next_is_last || room);
    accept       = in_valid && in_ready;
    push         = lat_q[PPU_LAT-1];
    out_valid    = (fifo_count != '0);
    pop          = out_valid && out_ready;
  end

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    win_cnt_d    = win_cnt_q;
    last_cnt_d   = last_cnt_q;
    out_cnt_d    = out_cnt_q;
    data_in_d    = data_in_q;
    mp_en_d      = 1'b0;
    mp_init_d    = 1'b0;
    zero_done_d  = 1'b0;
    drain_done   = 1'b0;
    issue_last_d = accept && next_is_last;
    lat_d        = (lat_q << 1) | PPU_LAT'(issue_last_q);

    if (accept) begin
      data_in_d = in_data;
      mp_en_d   = cfg_q.maxpool;
      mp_init_d = (win_cnt_q == 2'd0);
      if (cfg_q.maxpool) win_cnt_d = win_cnt_q + 2'd1;
    end
    if (pop) out_cnt_d = out_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d      = '{num_out:  CFG_CNT_W'(cfg_num_out),
                         maxpool:  cfg_maxpool,
                         relu_en:  cfg_relu_en,
                         relu_sel: cfg_relu_sel,
                         scale:    cfg_scale};
          win_cnt_d  = '0;
          last_cnt_d = '0;
          out_cnt_d  = '0;
          if (cfg_num_out == '0) zero_done_d = 1'b1;
          else                   state_d     = RUN;
        end
      end
      RUN: begin
        if (accept && next_is_last) begin
          last_cnt_d = last_cnt_q + CNT_W'(1);
          if (last_cnt_d == CNT_W'(cfg_q.num_out)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_cnt_d == CNT_W'(cfg_q.num_out))) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      win_cnt_q    <= '0;
      last_cnt_q   <= '0;
      out_cnt_q    <= '0;
      issue_last_q <= 1'b0;
      lat_q        <= '0;
      data_in_q    <= '0;
      mp_en_q      <= 1'b0;
      mp_init_q    <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      win_cnt_q    <= win_cnt_d;
      last_cnt_q   <= last_cnt_d;
      out_cnt_q    <= out_cnt_d;
      issue_last_q <= issue_last_d;
      lat_q        <= lat_d;
      data_in_q    <= data_in_d;
      mp_en_q      <= mp_en_d;
      mp_init_q    <= mp_init_d;
      zero_done_q  <= zero_done_d;
    end
  end

  ppu_ofifo #(.DEPTH(OFIFO_DEPTH)) u_ofifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ppu_data_out),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // The head is masked while empty so unwritten storage never reaches the port.
  assign out_data         = out_valid ? fifo_head : 8'h00;
  assign busy             = (state_q != IDLE);
  assign done             = drain_done || zero_done_q;
  assign ppu_data_in      = data_in_q;
  assign ppu_maxpool_en   = mp_en_q;
  assign ppu_maxpool_init = mp_init_q;
  assign ppu_scale        = cfg_q.scale;
  assign ppu_relu_en      = cfg_q.relu_en;
  assign ppu_relu_sel     = cfg_q.relu_sel;

endmodule

// File: tb/tb_ppu_ctrl.sv
// Directed bench for ppu_ctrl: behavioural PPU, scoreboard queue, per-pass counters.
module tb_ppu_ctrl;

  localparam int DATA_W      = 32;
  localparam int PPU_LAT     = 2;
  localparam int OFIFO_DEPTH = 4;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  cfg_num_out = '0;
  logic              cfg_maxpool = 1'b0;
  logic              cfg_relu_en = 1'b0;
  logic              cfg_relu_sel = 1'b0;
  logic [5:0]        cfg_scale = '0;
  logic              busy, done, in_ready, out_valid;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] ppu_data_in;
  logic [5:0]        ppu_scale;
  logic              ppu_maxpool_en, ppu_maxpool_init, ppu_relu_en, ppu_relu_sel;
  logic [7:0]        ppu_data_out;
  logic [7:0]        out_data;
  logic              out_ready = 1'b0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int pass_total, n_out, n_done, n_acc, n_en, n_beat, first_acc_cyc, first_out_cyc;
  logic [31:0] init_mask;
  logic [7:0]  exp_q [$];

  // Behavioural PPU: running max over a window, then ReLU and byte truncation, 2-cycle latency.
  logic [31:0] acc_q;
  logic [7:0]  res_q;

  function automatic logic [7:0] ref_byte(input logic [31:0] v, input logic relu);
    return (relu && v[31]) ? 8'h00 : v[7:0];
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ppu_maxpool_init) acc_q <= ppu_data_in;
    else if (ppu_maxpool_en && ($signed(ppu_data_in) > $signed(acc_q))) acc_q <= ppu_data_in;
    res_q <= ref_byte(acc_q, ppu_relu_en);
  end
  assign ppu_data_out = res_q;

  ppu_ctrl #(
    .DATA_W(DATA_W), .PPU_LAT(PPU_LAT), .OFIFO_DEPTH(OFIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_out(cfg_num_out), .cfg_maxpool(cfg_maxpool), .cfg_relu_en(cfg_relu_en),
    .cfg_relu_sel(cfg_relu_sel), .cfg_scale(cfg_scale),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ppu_data_in(ppu_data_in), .ppu_scale(ppu_scale),
    .ppu_maxpool_en(ppu_maxpool_en), .ppu_maxpool_init(ppu_maxpool_init),
    .ppu_relu_en(ppu_relu_en), .ppu_relu_sel(ppu_relu_sel),
    .ppu_data_out(ppu_data_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        n_acc++;
      end
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $error("FAIL spurious_out: observed byte %0d expected no output", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        n_out++;
      end
      if (done) begin
        n_done++;
        check("done_at_last_out", n_out, pass_total);
      end
      if (ppu_maxpool_en || ppu_maxpool_init) begin
        if (ppu_maxpool_init) init_mask = init_mask | (32'd1 << n_beat);
        if (ppu_maxpool_en) n_en++;
        n_beat++;
      end
    end
  end

  task automatic clr_stats(input int total);
    pass_total = total;
    n_out = 0; n_done = 0; n_acc = 0; n_en = 0; n_beat = 0;
    first_acc_cyc = -1; first_out_cyc = -1; init_mask = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int num, input logic mp, input logic re, input logic rs,
                          input logic [5:0] sc);
    start = 1'b1; cfg_num_out = CNT_W'(num); cfg_maxpool = mp;
    cfg_relu_en = re; cfg_relu_sel = rs; cfg_scale = sc;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      tick();
      i++;
    end
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_vals [4];
    logic [31:0] mp_vals [8];
    logic [31:0] m;
    bp_vals = '{32'd10, 32'd20, 32'd30, 32'd40};
    mp_vals = '{32'd5, 32'd300, -32'sd7, 32'd3, -32'sd10, -32'sd3, -32'sd50, -32'sd8};
    clr_stats(0);

    // Reset values
    repeat (3) tick();
    check("rst_ctrl_outs", {24'd0, busy, done, in_ready, out_valid, ppu_maxpool_en,
                            ppu_maxpool_init, ppu_relu_en, ppu_relu_sel}, 32'd0);
    check("rst_scale_outdata", {18'd0, ppu_scale, out_data}, 32'd0);
    check("rst_ppu_data_in", ppu_data_in, 32'd0);
    rst = 1'b0;
    tick();

    // Bypass: four results, no throttling, first result PPU_LAT+2 falling edges after the first accept
    clr_stats(4);
    out_ready = 1'b1;
    do_start(4, 1'b0, 1'b0, 1'b0, 6'd5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_scale", 32'(ppu_scale), 32'd5);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_byte(bp_vals[i], 1'b0));
      send(bp_vals[i]);
    end
    check("t1_no_stall", n_acc, 4);
    wait_done(100);
    check("t1_outputs", n_out, 4);
    check("t1_done_count", n_done, 1);
    check("t1_first_out_latency", first_out_cyc - first_acc_cyc, PPU_LAT + 2);
    check("t1_beats_init_each", init_mask, 32'h0000_000f);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Maxpool: two 2x2 windows of four beats each
    clr_stats(2);
    do_start(2, 1'b1, 1'b1, 1'b0, 6'd3);
    check("t2_relu_en", 32'(ppu_relu_en), 32'd1);
    for (int w = 0; w < 2; w++) begin
      m = mp_vals[w*4];
      for (int k = 1; k < 4; k++)
        if ($signed(mp_vals[w*4+k]) > $signed(m)) m = mp_vals[w*4+k];
      exp_q.push_back(ref_byte(m, 1'b1));
      for (int k = 0; k < 4; k++) send(mp_vals[w*4+k]);
    end
    wait_done(100);
    check("t2_init_mask", init_mask, 32'h0000_0011);
    check("t2_en_count", n_en, 8);
    check("t2_outputs", n_out, 2);
    check("t2_done_count", n_done, 1);

    // Backpressure: credit stops the input once the FIFO plus in-flight results reach its depth
    clr_stats(16);
    out_ready = 1'b0;
    do_start(16, 1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(i * 7 + 1));
      send(32'(i * 7 + 1));
    end
    in_valid = 1'b1;
    in_data  = 32'd29;
    exp_q.push_back(8'd29);
    repeat (10) tick();
    check("t3_accepts_before_stall", n_acc, OFIFO_DEPTH);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_out_valid_held", 32'(out_valid), 32'd1);
    check("t3_head_held", 32'(out_data), 32'(exp_q[0]));
    out_ready = 1'b1;
    send(32'd29);
    for (int i = 5; i < 16; i++) begin
      exp_q.push_back(8'(i * 7 + 1));
      send(32'(i * 7 + 1));
    end
    wait_done(200);
    check("t3_outputs", n_out, 16);
    check("t3_done_count", n_done, 1);
    check("t3_scoreboard_empty", exp_q.size(), 0);

    // Zero-length pass
    clr_stats(0);
    do_start(0, 1'b1, 1'b0, 1'b0, 6'd0);
    check("t4_done_next_cycle", 32'(done), 32'd1);
    check("t4_busy_low", 32'(busy), 32'd0);
    tick();
    check("t4_done_one_cycle", 32'(done), 32'd0);
    repeat (3) tick();
    check("t4_done_count", n_done, 1);
    check("t4_no_ppu_beats", n_beat, 0);

    // Mid-pass reset, then a fresh single-output pass
    clr_stats(8);
    do_start(8, 1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) send(32'(100 + i));
    check("t5_accepts", n_acc, 3);
    rst = 1'b1;
    tick();
    check("t5_after_reset", {29'd0, busy, out_valid, in_ready}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    clr_stats(1);
    do_start(1, 1'b0, 1'b0, 1'b0, 6'd0);
    exp_q.push_back(8'd77);
    send(32'd77);
    wait_done(100);
    check("t5_outputs", n_out, 1);
    check("t5_done_count", n_done, 1);

    // A start pulse while busy must not disturb the running pass
    clr_stats(3);
    do_start(3, 1'b0, 1'b1, 1'b1, 6'd9);
    exp_q.push_back(8'd50);
    send(32'd50);
    do_start(7, 1'b1, 1'b0, 1'b0, 6'd2);
    check("t6_scale_kept", 32'(ppu_scale), 32'd9);
    check("t6_relu_kept", {30'd0, ppu_relu_en, ppu_relu_sel}, 32'd3);
    exp_q.push_back(ref_byte(-32'sd5, 1'b1));
    send(-32'sd5);
    exp_q.push_back(8'd200);
    send(32'd200);
    wait_done(100);
    check("t6_outputs", n_out, 3);
    check("t6_done_count", n_done, 1);
    check("t6_no_maxpool", n_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
